tmp_controller: RTL and testbench

//  Test-Mode-Persistence controller for the JTAG TAP. Consumes the decoder's clamp_hold_decode,

---
 rtl/jtag_types_pkg.sv | 14 +
 rtl/tmp_controller_if.sv | 32 +++
 rtl/tmp_status_reg.sv | 44 ++++
 rtl/tmp_controller.sv | 96 +++++++++
 tb/tb_tmp_controller.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/jtag_types_pkg.sv
// Shared JTAG types for the Test-Mode-Persistence (TMP) controller.
//   tmp_state_t  : persistence FSM states
//   TMP_STATUS_W : default width of the TMP status data register
package jtag_types_pkg;

  typedef enum logic [1:0] {
    TMP_OFF   = 2'd0,
    TMP_ON    = 2'd1,
    TMP_ARMED = 2'd2
  } tmp_state_t;

  localparam int unsigned TMP_STATUS_W = 2;

endpackage

// File: rtl/tmp_controller_if.sv
// TAP-side signal bundle for tmp_controller.
//   master : TAP/decoder side, drives strobes and serial in, observes outputs
//   slave  : tmp_controller, consumes strobes, drives tmp_tdo/bsr_mode/persist_on
interface tmp_controller_if;
  logic update_ir;
  logic test_logic_reset;
  logic capture_dr;
  logic shift_dr;
  logic clamp_hold_decode;
  logic clamp_release_decode;
  logic bypass_decode;
  logic test_mode_decode;
  logic tmp_select;
  logic tdi;
  logic tmp_tdo;
  logic bsr_mode;
  logic persist_on;

  modport master (
    output update_ir, test_logic_reset, capture_dr, shift_dr,
    output clamp_hold_decode, clamp_release_decode, bypass_decode, test_mode_decode,
    output tmp_select, tdi,
    input  tmp_tdo, bsr_mode, persist_on
  );

  modport slave (
    input  update_ir, test_logic_reset, capture_dr, shift_dr,
    input  clamp_hold_decode, clamp_release_decode, bypass_decode, test_mode_decode,
    input  tmp_select, tdi,
    output tmp_tdo, bsr_mode, persist_on
  );
endinterface

// File: rtl/tmp_status_reg.sv
// Capture/shift data register (no update stage).
//   clk, rst_n : clock, async active-low reset (clears q)
//   sel        : register selected; capture/shift ignored otherwise
//   capture_dr : load cap_val (wins over shift_dr)
//   shift_dr   : shift right, tdi enters at MSB, q[0] is the serial out
//   cap_val    : parallel capture value
//   q          : register contents
module tmp_status_reg #(
  parameter int unsigned Width = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sel,
  input  logic             capture_dr,
  input  logic             shift_dr,
  input  logic             tdi,
  input  logic [Width-1:0] cap_val,
  output logic [Width-1:0] q
);

  logic [Width-1:0] q_d, q_q;

  always_comb begin
    q_d = q_q;
    if (sel) begin
      if (capture_dr) begin
        q_d = cap_val;
      end else if (shift_dr) begin
        q_d = {tdi, q_q[Width-1:1]};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/tmp_controller.sv
// Test-Mode-Persistence controller for the JTAG TAP.
// Keeps boundary scan in test mode across Test-Logic-Reset while persistence is on,
// drives bsr_mode and owns the TMP status data register.
//   TCK   : TAP clock
//   nTRST : async active-low reset
//   tap   : strobes in (update_ir, test_logic_reset, capture_dr, shift_dr, *_decode,
//           tmp_select, tdi), outputs tmp_tdo, bsr_mode, persist_on
module tmp_controller
  import jtag_types_pkg::*;
#(
  parameter int unsigned STATUS_W      = TMP_STATUS_W,
  parameter bit          RESET_PERSIST = 1'b0
) (
  input  logic             TCK,
  input  logic             nTRST,
  tmp_controller_if.slave  tap
);

  localparam tmp_state_t ResetState = RESET_PERSIST ? TMP_ON : TMP_OFF;

  tmp_state_t state_d, state_q;
  logic       bsr_mode_d, bsr_mode_q;

  // Next state. test_logic_reset beats update_ir; decode priority is
  // clamp_hold > clamp_release > test_mode > bypass.
  always_comb begin
    state_d    = state_q;
    bsr_mode_d = bsr_mode_q;
    if (tap.test_logic_reset) begin
      // TMP_ON persists through TLR; only an armed release drops out.
      if (state_q == TMP_ARMED) begin
        state_d = TMP_OFF;
      end
      bsr_mode_d = (state_d != TMP_OFF);
    end else if (tap.update_ir) begin
      case (state_q)
        TMP_OFF: begin
          if (tap.clamp_hold_decode) state_d = TMP_ON;
        end
        TMP_ON: begin
          if (!tap.clamp_hold_decode && tap.clamp_release_decode) state_d = TMP_ARMED;
        end
        TMP_ARMED: begin
          if (tap.clamp_hold_decode) begin
            state_d = TMP_ON;
          end else if (tap.clamp_release_decode) begin
            state_d = TMP_OFF;
          end else if (tap.test_mode_decode) begin
            state_d = TMP_ON;
          end else begin
            state_d = TMP_OFF;
          end
        end
        default: state_d = TMP_OFF;
      endcase
      bsr_mode_d = (state_d != TMP_OFF) | tap.test_mode_decode;
    end
  end

  always_ff @(posedge TCK or negedge nTRST) begin
    if (!nTRST) begin
      state_q    <= ResetState;
      bsr_mode_q <= RESET_PERSIST;
    end else begin
      state_q    <= state_d;
      bsr_mode_q <= bsr_mode_d;
    end
  end

  logic [STATUS_W-1:0] cap_val;
  logic [STATUS_W-1:0] status_q;

  always_comb begin
    cap_val    = '0;
    cap_val[0] = (state_q != TMP_OFF);
    cap_val[1] = (state_q == TMP_ARMED);
  end

  tmp_status_reg #(
    .Width (STATUS_W)
  ) u_status (
    .clk        (TCK),
    .rst_n      (nTRST),
    .sel        (tap.tmp_select),
    .capture_dr (tap.capture_dr),
    .shift_dr   (tap.shift_dr),
    .tdi        (tap.tdi),
    .cap_val    (cap_val),
    .q          (status_q)
  );

  assign tap.tmp_tdo    = status_q[0];
  assign tap.bsr_mode   = bsr_mode_q;
  assign tap.persist_on = (state_q != TMP_OFF);

endmodule

// File: tb/tb_tmp_controller.sv
module tb_tmp_controller;

  logic TCK;
  logic nTRST;
  int   n_checks;
  int   n_errors;

  tmp_controller_if tap_if ();

  tmp_controller u_dut (
    .TCK   (TCK),
    .nTRST (nTRST),
    .tap   (tap_if)
  );

  initial TCK = 1'b0;
  always #5 TCK = ~TCK;

  // Reference model: "holding" = persistence engaged, "armed" = release pending.
  bit         m_persist;
  bit         m_armed;
  bit         m_bsr;
  logic [1:0] m_status;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_persist = 1'b0;
    m_armed   = 1'b0;
    m_bsr     = 1'b0;
    m_status  = 2'b00;
  endtask

  // Advance the model by one TCK using the inputs currently applied.
  task automatic model_tick();
    bit hold_held;
    if (tap_if.tmp_select) begin
      if (tap_if.capture_dr) begin
        m_status = 2'(m_armed) * 2 + 2'(m_persist);
      end else if (tap_if.shift_dr) begin
        m_status = 2'(tap_if.tdi) * 2 + (m_status / 2);
      end
    end
    if (tap_if.test_logic_reset) begin
      if (m_armed) begin
        m_persist = 1'b0;
        m_armed   = 1'b0;
      end
      m_bsr = m_persist;
    end else if (tap_if.update_ir) begin
      hold_held = tap_if.clamp_hold_decode;
      if (!m_persist) begin
        m_persist = hold_held;
      end else if (!m_armed) begin
        m_armed = !hold_held && tap_if.clamp_release_decode;
      end else if (hold_held ||
                   (!tap_if.clamp_release_decode && tap_if.test_mode_decode)) begin
        m_armed = 1'b0;
      end else begin
        m_persist = 1'b0;
        m_armed   = 1'b0;
      end
      m_bsr = m_persist | tap_if.test_mode_decode;
    end
  endtask

  task automatic clear_inputs();
    tap_if.update_ir            = 1'b0;
    tap_if.test_logic_reset     = 1'b0;
    tap_if.capture_dr           = 1'b0;
    tap_if.shift_dr             = 1'b0;
    tap_if.clamp_hold_decode    = 1'b0;
    tap_if.clamp_release_decode = 1'b0;
    tap_if.bypass_decode        = 1'b0;
    tap_if.test_mode_decode     = 1'b0;
    tap_if.tmp_select           = 1'b0;
    tap_if.tdi                  = 1'b0;
  endtask

  task automatic step();
    model_tick();
    @(posedge TCK);
    #1;
    check("persist_on", 32'(tap_if.persist_on), 32'(m_persist));
    check("bsr_mode", 32'(tap_if.bsr_mode), 32'(m_bsr));
    check("tmp_tdo", 32'(tap_if.tmp_tdo), 32'(m_status[0]));
  endtask

  task automatic do_ir(input bit hold, input bit rel, input bit tm, input bit byp);
    clear_inputs();
    tap_if.update_ir            = 1'b1;
    tap_if.clamp_hold_decode    = hold;
    tap_if.clamp_release_decode = rel;
    tap_if.test_mode_decode     = tm;
    tap_if.bypass_decode        = byp;
    step();
    clear_inputs();
  endtask

  // Assert nTRST between clock edges and check outputs without any TCK edge.
  task automatic mid_cycle_reset();
    @(negedge TCK);
    #1;
    nTRST = 1'b0;
    model_reset();
    #1;
    check("rst_bsr_mode", 32'(tap_if.bsr_mode), 32'd0);
    check("rst_persist_on", 32'(tap_if.persist_on), 32'd0);
    check("rst_tmp_tdo", 32'(tap_if.tmp_tdo), 32'd0);
    #1;
    nTRST = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    nTRST    = 1'b0;
    clear_inputs();
    model_reset();
    repeat (2) @(posedge TCK);
    #1;
    nTRST = 1'b1;
    step();

    // Get into a non-reset state, then reset mid-cycle.
    do_ir(1, 0, 0, 0);
    mid_cycle_reset();

    // Hold survives Test-Logic-Reset.
    do_ir(1, 0, 0, 0);
    check("hold_bsr", 32'(tap_if.bsr_mode), 32'd1);
    check("hold_persist", 32'(tap_if.persist_on), 32'd1);
    tap_if.test_logic_reset = 1'b1;
    repeat (5) step();
    clear_inputs();
    check("hold_tlr_bsr", 32'(tap_if.bsr_mode), 32'd1);
    check("hold_tlr_persist", 32'(tap_if.persist_on), 32'd1);

    // Release then bypass drops to off.
    do_ir(0, 1, 0, 0);
    check("armed_bsr", 32'(tap_if.bsr_mode), 32'd1);
    check("armed_persist", 32'(tap_if.persist_on), 32'd1);
    do_ir(0, 0, 0, 1);
    check("release_bsr", 32'(tap_if.bsr_mode), 32'd0);
    check("release_persist", 32'(tap_if.persist_on), 32'd0);

    // Re-arm via test-mode instruction, then TLR from armed.
    do_ir(1, 0, 0, 0);
    do_ir(0, 1, 0, 0);
    do_ir(0, 0, 1, 0);
    check("rearm_persist", 32'(tap_if.persist_on), 32'd1);
    check("rearm_bsr", 32'(tap_if.bsr_mode), 32'd1);
    do_ir(0, 1, 0, 0);
    tap_if.test_logic_reset = 1'b1;
    step();
    clear_inputs();
    check("armed_tlr_bsr", 32'(tap_if.bsr_mode), 32'd0);
    check("armed_tlr_persist", 32'(tap_if.persist_on), 32'd0);

    // Status DR while armed: capture 2'b11, shift in 1 then 0.
    do_ir(1, 0, 0, 0);
    do_ir(0, 1, 0, 0);
    tap_if.tmp_select = 1'b1;
    tap_if.capture_dr = 1'b1;
    step();
    check("cap_tdo", 32'(tap_if.tmp_tdo), 32'd1);
    tap_if.capture_dr = 1'b0;
    tap_if.shift_dr   = 1'b1;
    tap_if.tdi        = 1'b1;
    step();
    check("shift1_tdo", 32'(tap_if.tmp_tdo), 32'd1);
    tap_if.tdi = 1'b0;
    step();
    check("shift2_tdo", 32'(tap_if.tmp_tdo), 32'd1);
    step();
    check("shift3_tdo", 32'(tap_if.tmp_tdo), 32'd0);
    clear_inputs();

    // Glitch immunity: strobes toggle without update_ir.
    for (int i = 0; i < 8; i++) begin
      tap_if.clamp_hold_decode    = 1'($urandom);
      tap_if.clamp_release_decode = 1'($urandom);
      tap_if.bypass_decode        = 1'($urandom);
      tap_if.test_mode_decode     = 1'($urandom);
      step();
    end
    clear_inputs();
    check("glitch_persist", 32'(tap_if.persist_on), 32'd1);
    check("glitch_bsr", 32'(tap_if.bsr_mode), 32'd1);

    // Multi-hot from off: clamp_hold wins.
    mid_cycle_reset();
    do_ir(1, 1, 0, 0);
    check("multihot_persist", 32'(tap_if.persist_on), 32'd1);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      if (i % 250 == 249) begin
        mid_cycle_reset();
      end
      tap_if.update_ir            = ($urandom_range(0, 99) < 35);
      tap_if.test_logic_reset     = ($urandom_range(0, 99) < 10);
      tap_if.clamp_hold_decode    = ($urandom_range(0, 99) < 25);
      tap_if.clamp_release_decode = ($urandom_range(0, 99) < 30);
      tap_if.bypass_decode        = ($urandom_range(0, 99) < 25);
      tap_if.test_mode_decode     = ($urandom_range(0, 99) < 25);
      tap_if.tmp_select           = ($urandom_range(0, 99) < 60);
      tap_if.capture_dr           = ($urandom_range(0, 99) < 20);
      tap_if.shift_dr             = ($urandom_range(0, 99) < 50);
      tap_if.tdi                  = 1'($urandom);
      step();
    end
    clear_inputs();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
